// File: rtl/demux1_to4_stream.sv
// demux1_to4_stream: registered 1-to-4 valid/ready stream demultiplexer with per-channel transfer counters
module demux1_to4_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WIDTH-1:0]     s_data,
   input  logic [1:0]           s_sel,
   output logic [3:0]           m_valid,
   input  logic [3:0]           m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic [1:0]           m_sel,
   input  logic                 cnt_clr,
   output logic [4*CNT_W-1:0]   cnt
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t                    state_q, state_d;
   logic [WIDTH-1:0]          data_q, data_d;
   logic [1:0]                sel_q, sel_d;
   logic [3:0][CNT_W-1:0]     cnt_q, cnt_d;
   logic                      load, drain;
   always_comb begin
      drain   = (state_q == FULL) && m_ready[sel_q];
      s_ready = (state_q == EMPTY) || m_ready[sel_q];
      load    = s_valid && s_ready;
      state_d = load ? FULL : drain ? EMPTY : state_q;
      data_d  = load ? s_data : data_q;
      sel_d   = load ? s_sel : sel_q;
      m_valid = '0;
      m_valid[sel_q] = (state_q == FULL);
   end
   // clear takes priority over a same-cycle drain increment
   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < 4; k++)
         cnt_d[k] = cnt_clr ? '0 : (drain && sel_q == 2'(k)) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end
   assign m_data = data_q;
   assign m_sel  = sel_q;
   assign cnt    = cnt_q;
endmodule

// File: tb/tb_demux1_to4_stream.sv
// tb_demux1_to4_stream: vector table, corner sequences and random traffic against a queue-based model
module tb_demux1_to4_stream;
   localparam int W = 8;
   localparam int CW = 4;
   logic clk = 0, rst_n = 0, s_valid = 0, s_ready, cnt_clr = 0;
   logic [W-1:0] s_data = 0, m_data;
   logic [1:0] s_sel = 0, m_sel;
   logic [3:0] m_valid, m_ready = 0;
   logic [4*CW-1:0] cnt;
   int n_chk = 0, n_fail = 0;

   typedef struct {logic [W-1:0] d; logic [1:0] s;} word_t;
   typedef struct {
      logic sv; logic [W-1:0] sd; logic [1:0] ss; logic [3:0] mr;
      logic sr; logic [3:0] mv; logic [W-1:0] md; logic [15:0] c;
   } vec_t;

   word_t q[$];
   int drains[4];
   logic [W-1:0] last_d;
   logic [1:0] last_s;
   vec_t tbl[15];

   demux1_to4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sel(s_sel), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_sel(m_sel), .cnt_clr(cnt_clr), .cnt(cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      drains = '{default: 0};
      last_d = '0;
      last_s = '0;
   endtask

   task automatic check_outputs();
      logic [3:0] mv;
      mv = '0;
      if (q.size() != 0) mv = 4'b0001 << q[0].s;
      chk("m_valid", m_valid, mv);
      chk("m_data", m_data, last_d);
      chk("m_sel", m_sel, last_s);
      for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), cnt[i*CW +: CW], drains[i] % (1 << CW));
   endtask

   task automatic step(input logic sv, input logic [W-1:0] sd, input logic [1:0] ss,
                       input logic [3:0] mr, input logic clr);
      logic exp_sr, dr, ld;
      s_valid = sv; s_data = sd; s_sel = ss; m_ready = mr; cnt_clr = clr;
      #1;
      exp_sr = (q.size() == 0) || mr[q[0].s];
      chk("s_ready", s_ready, exp_sr);
      dr = (q.size() != 0) && mr[q[0].s];
      ld = sv && exp_sr;
      @(posedge clk);
      if (dr) begin
         drains[q[0].s]++;
         void'(q.pop_front());
      end
      if (ld) begin
         q.push_back('{sd, ss});
         last_d = sd;
         last_s = ss;
      end
      if (clr) drains = '{default: 0};
      #1;
      check_outputs();
   endtask

   initial begin
      tbl[0]  = '{1, 8'hA0, 2'd0, 4'hF, 1, 4'b0001, 8'hA0, 16'h0000};
      tbl[1]  = '{1, 8'hA1, 2'd1, 4'hF, 1, 4'b0010, 8'hA1, 16'h0001};
      tbl[2]  = '{1, 8'hA2, 2'd2, 4'hF, 1, 4'b0100, 8'hA2, 16'h0011};
      tbl[3]  = '{1, 8'hA3, 2'd3, 4'hF, 1, 4'b1000, 8'hA3, 16'h0111};
      tbl[4]  = '{0, 8'h00, 2'd0, 4'hF, 1, 4'b0000, 8'hA3, 16'h1111};
      tbl[5]  = '{1, 8'h5A, 2'd3, 4'h7, 1, 4'b1000, 8'h5A, 16'h1111};
      for (int i = 6; i <= 10; i++) tbl[i] = '{1, 8'h77, 2'd0, 4'h7, 0, 4'b1000, 8'h5A, 16'h1111};
      tbl[11] = '{0, 8'h00, 2'd0, 4'h8, 1, 4'b0000, 8'h5A, 16'h2111};
      tbl[12] = '{1, 8'h33, 2'd0, 4'h0, 1, 4'b0001, 8'h33, 16'h2111};
      tbl[13] = '{1, 8'h44, 2'd2, 4'h1, 1, 4'b0100, 8'h44, 16'h2112};
      tbl[14] = '{0, 8'h00, 2'd0, 4'h4, 1, 4'b0000, 8'h44, 16'h2212};

      model_reset();
      #1;
      chk("rst m_valid", m_valid, 4'b0000);
      chk("rst s_ready", s_ready, 1'b1);
      chk("rst m_data", m_data, 0);
      chk("rst cnt", cnt, 0);
      repeat (2) @(posedge clk);
      #4 rst_n = 1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 15; i++) begin
         logic sr_now;
         s_valid = tbl[i].sv; m_ready = tbl[i].mr;
         #0;
         sr_now = s_ready;
         step(tbl[i].sv, tbl[i].sd, tbl[i].ss, tbl[i].mr, 1'b0);
         chk($sformatf("vec%0d s_ready", i), sr_now, tbl[i].sr);
         chk($sformatf("vec%0d m_valid", i), m_valid, tbl[i].mv);
         chk($sformatf("vec%0d m_data", i), m_data, tbl[i].md);
         chk($sformatf("vec%0d cnt", i), cnt, tbl[i].c);
      end

      step(1, 8'hC2, 2'd2, 4'h0, 0);
      step(0, 8'h00, 2'd0, 4'h0, 0);
      rst_n = 0;
      #1;
      model_reset();
      chk("async m_valid", m_valid, 4'b0000);
      chk("async s_ready", s_ready, 1'b1);
      chk("async cnt", cnt, 0);
      chk("async m_data", m_data, 0);
      #2 rst_n = 1;
      @(posedge clk);
      #1;
      step(1, 8'h11, 2'd1, 4'h0, 0);
      chk("post-rst m_valid", m_valid, 4'b0010);
      chk("post-rst m_data", m_data, 8'h11);
      step(0, 8'h00, 2'd0, 4'hF, 0);

      step(0, 8'h00, 2'd0, 4'hF, 1);
      for (int k = 0; k < 17; k++) step(1, 8'(k), 2'd1, 4'hF, 0);
      step(0, 8'h00, 2'd0, 4'hF, 0);
      chk("wrap cnt1", cnt[CW +: CW], 4'd1);
      step(1, 8'hEE, 2'd1, 4'h0, 0);
      step(0, 8'h00, 2'd0, 4'h2, 1);
      chk("clr-wins cnt1", cnt[CW +: CW], 4'd0);

      for (int k = 0; k < 3000; k++)
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 4'($urandom),
              1'($urandom_range(0, 31) == 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
